// File: rtl/slider_moves.sv
// Sliding-piece move generator: fetches a board over the master port, finds the
// rook/bishop/queen, and writes one full board image per legal move.
module slider_moves #(
  parameter int MAX_MOVES = 27,
  parameter int BOARD_SQ  = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);
  localparam int SW = $clog2(BOARD_SQ);
  localparam logic [SW-1:0] LAST_SQ = SW'(BOARD_SQ - 1);
  localparam logic [7:0] MAX_CNT = 8'(MAX_MOVES);

  typedef enum logic [2:0] {IDLE, READ_BOARD, FIND, WALK, WRITE_BOARD, DONE} state_t;
  state_t state, state_next;

  logic [31:0]   src_addr, dst_addr;
  logic [7:0]    piece_id;
  logic [7:0]    count;
  logic          overflow;
  logic [7:0]    board [BOARD_SQ];
  logic [SW-1:0] idx;
  logic          rd_pending;
  logic [SW-1:0] src_sq, cur_sq, tgt_sq;
  logic [2:0]    dir, dir_last;
  logic          capture;

  // Piece type from |ID|; the direction window follows from the type.
  logic [7:0] id_abs;
  logic       is_rook, is_bishop, is_queen, type_ok;
  logic [2:0] dir_first, dir_stop;
  assign id_abs    = piece_id[7] ? (~piece_id + 8'd1) : piece_id;
  assign is_rook   = (id_abs >= 8'd9)  && (id_abs <= 8'd18);
  assign is_bishop = (id_abs >= 8'd29) && (id_abs <= 8'd38);
  assign is_queen  = (id_abs >= 8'd39) && (id_abs <= 8'd47);
  assign type_ok   = is_rook || is_bishop || is_queen;
  assign dir_first = is_bishop ? 3'd4 : 3'd0;
  assign dir_stop  = is_rook ? 3'd3 : 3'd7;

  // Step geometry: N, S, E, W, NE, NW, SE, SW as rank/file deltas.
  logic signed [4:0] dr, df, nr, nf;
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    dr = 5'sd0;
    df = 5'sd0;
    case (dir)
      3'd0: dr = 5'sd1;
      3'd1: dr = -5'sd1;
      3'd2: df = 5'sd1;
      3'd3: df = -5'sd1;
      3'd4: begin dr = 5'sd1;  df = 5'sd1;  end
      3'd5: begin dr = 5'sd1;  df = -5'sd1; end
      3'd6: begin dr = -5'sd1; df = 5'sd1;  end
      default: begin dr = -5'sd1; df = -5'sd1; end
    endcase
  end

  assign nr = $signed({2'b00, cur_sq[5:3]}) + dr;
  assign nf = $signed({2'b00, cur_sq[2:0]}) + df;

  logic          on_board, t_empty, t_same, legal, last_dir;
  logic [SW-1:0] tgt_next;
  logic [7:0]    t_val;
  assign on_board = (nr[4:3] == 2'b00) && (nf[4:3] == 2'b00);
  assign tgt_next = SW'({nr[2:0], nf[2:0]});
  assign t_val    = board[tgt_next];
  assign t_empty  = (t_val == 8'd0);
  assign t_same   = !t_empty && (t_val[7] == piece_id[7]);
  assign legal    = on_board && !t_same;
  assign last_dir = (dir == dir_last);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next        = state;
    slave_waitrequest = 1'b0;
    master_read       = 1'b0;
    master_write      = 1'b0;
    master_address    = 32'd0;
    master_writedata  = 32'd0;
    case (state)
      IDLE: begin
        if (slave_write && slave_address == 4'd0) state_next = READ_BOARD;
      end
      READ_BOARD: begin
        slave_waitrequest = 1'b1;
        master_read       = !rd_pending;
        master_address    = src_addr + 32'(idx);
        if (rd_pending && master_readdatavalid && idx == LAST_SQ) state_next = FIND;
      end
      FIND: begin
        slave_waitrequest = 1'b1;
        if (!type_ok)                    state_next = DONE;
        else if (board[idx] == piece_id) state_next = WALK;
        else if (idx == LAST_SQ)         state_next = DONE;
      end
      WALK: begin
        slave_waitrequest = 1'b1;
        if (!legal) begin
          if (last_dir) state_next = DONE;
        end else if (count == MAX_CNT) begin
          state_next = DONE;
        end else begin
          state_next = WRITE_BOARD;
        end
      end
      WRITE_BOARD: begin
        slave_waitrequest = 1'b1;
        master_write      = 1'b1;
        master_address    = dst_addr + 32'(count) * 32'(BOARD_SQ) + 32'(idx);
        if (idx == src_sq)      master_writedata = 32'd0;
        else if (idx == tgt_sq) master_writedata = {24'd0, piece_id};
        else                    master_writedata = {24'd0, board[idx]};
        if (!master_waitrequest && idx == LAST_SQ)
          state_next = (capture && last_dir) ? DONE : WALK;
      end
      DONE: begin
        // Finishes a pending status read; writes still wait for IDLE.
        slave_waitrequest = slave_write;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    slave_readdata = 32'd0;
    case (slave_address)
      4'd0: slave_readdata = {overflow, 23'd0, count};
      4'd1: slave_readdata = src_addr;
      4'd2: slave_readdata = {24'd0, piece_id};
      4'd3: slave_readdata = dst_addr;
      default: slave_readdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_addr   <= 32'd0;
      dst_addr   <= 32'd0;
      piece_id   <= 8'd0;
      count      <= 8'd0;
      overflow   <= 1'b0;
      idx        <= '0;
      rd_pending <= 1'b0;
      src_sq     <= '0;
      cur_sq     <= '0;
      tgt_sq     <= '0;
      dir        <= 3'd0;
      dir_last   <= 3'd0;
      capture    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (slave_write) begin
            case (slave_address)
              4'd0: begin
                count      <= 8'd0;
                overflow   <= 1'b0;
                idx        <= '0;
                rd_pending <= 1'b0;
              end
              4'd1: src_addr <= slave_writedata;
              4'd2: piece_id <= slave_writedata[7:0];
              4'd3: dst_addr <= slave_writedata;
              default: ;
            endcase
          end
        end
        READ_BOARD: begin
          if (!rd_pending) begin
            if (!master_waitrequest) rd_pending <= 1'b1;
          end else if (master_readdatavalid) begin
            rd_pending <= 1'b0;
            idx        <= idx + 1'b1;
          end
        end
        FIND: begin
          // Only the values latched on the matching square are ever used.
          idx      <= idx + 1'b1;
          src_sq   <= idx;
          cur_sq   <= idx;
          dir      <= dir_first;
          dir_last <= dir_stop;
        end
        WALK: begin
          if (!legal) begin
            if (!last_dir) begin
              dir    <= dir + 3'd1;
              cur_sq <= src_sq;
            end
          end else if (count == MAX_CNT) begin
            overflow <= 1'b1;
          end else begin
            tgt_sq  <= tgt_next;
            capture <= !t_empty;
            idx     <= '0;
          end
        end
        WRITE_BOARD: begin
          if (!master_waitrequest) begin
            idx <= idx + 1'b1;
            if (idx == LAST_SQ) begin
              count <= count + 8'd1;
              if (capture) begin
                dir    <= dir + 3'd1;
                cur_sq <= src_sq;
              end else begin
                cur_sq <= tgt_sq;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the board store is plain data fully overwritten before any use, so
  // it carries no reset and can map onto RAM or unreset flops.
  always_ff @(posedge clk) begin
    if (state == READ_BOARD && rd_pending && master_readdatavalid)
      board[idx] <= master_readdata[7:0];
  end
endmodule

// File: tb/tb_slider_moves.sv
// Directed bench for slider_moves: byte-wide memory model on the master port,
// register host on the slave port, two instances for the MAX_MOVES variants.
module tb_slider_moves;
  localparam int SRC = 32'h100;
  localparam int DST = 32'h800;
  localparam int BUDGET = 40000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        sel;
  logic [3:0]  s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata, s_readdata;
  logic        s_waitrequest;
  logic        m_waitrequest, m_readdatavalid;
  logic [31:0] m_readdata, m_address, m_writedata;
  logic        m_read, m_write;

  logic        swq0, swq1, mrd0, mrd1, mwr0, mwr1;
  logic [31:0] srd0, srd1, mad0, mad1, mwd0, mwd1;

  slider_moves dut (
    .clk(clk), .rst(rst),
    .slave_waitrequest(swq0), .slave_address(s_address),
    .slave_read(s_read && !sel), .slave_readdata(srd0),
    .slave_write(s_write && !sel), .slave_writedata(s_writedata),
    .master_waitrequest(m_waitrequest), .master_address(mad0),
    .master_read(mrd0), .master_readdata(m_readdata),
    .master_readdatavalid(m_readdatavalid), .master_write(mwr0),
    .master_writedata(mwd0)
  );

  slider_moves #(.MAX_MOVES(8)) dut8 (
    .clk(clk), .rst(rst),
    .slave_waitrequest(swq1), .slave_address(s_address),
    .slave_read(s_read && sel), .slave_readdata(srd1),
    .slave_write(s_write && sel), .slave_writedata(s_writedata),
    .master_waitrequest(m_waitrequest), .master_address(mad1),
    .master_read(mrd1), .master_readdata(m_readdata),
    .master_readdatavalid(m_readdatavalid), .master_write(mwr1),
    .master_writedata(mwd1)
  );

  assign s_waitrequest = sel ? swq1 : swq0;
  assign s_readdata    = sel ? srd1 : srd0;
  assign m_read        = sel ? mrd1 : mrd0;
  assign m_write       = sel ? mwr1 : mwr0;
  assign m_address     = sel ? mad1 : mad0;
  assign m_writedata   = sel ? mwd1 : mwd0;

  // Memory model: one-cycle read latency, optional random stalls.
  logic [7:0] mem [8192];
  logic [7:0] srcb [64];
  logic [7:0] ref_img [192];
  logic       pend = 1'b0;
  logic [7:0] pend_data = 8'd0;
  bit         stall_en = 1'b0;
  int         write_count = 0;
  int         both_count = 0;

  always @(negedge clk) begin
    m_readdatavalid = pend;
    m_readdata      = {24'd0, pend_data};
    m_waitrequest   = stall_en && ($urandom_range(0, 2) == 0);
    pend            = m_read && !m_waitrequest && !rst;
    if (pend) pend_data = mem[m_address[12:0]];
    if (m_write && !m_waitrequest) begin
      mem[m_address[12:0]] = m_writedata[7:0];
      write_count++;
    end
    if (m_read && m_write) both_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out after %0d cycles", tag, BUDGET);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    s_address = a; s_writedata = d; s_write = 1'b1;
    #1;
    while (s_waitrequest && n < BUDGET) begin @(negedge clk); #1; n++; end
    if (n >= BUDGET) timeout_fail("host_write");
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    s_address = a; s_read = 1'b1;
    #1;
    while (s_waitrequest && n < BUDGET) begin @(negedge clk); #1; n++; end
    if (n >= BUDGET) timeout_fail("host_read");
    d = s_readdata;
    @(posedge clk); #1;
    s_read = 1'b0;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 64; i++) srcb[i] = 8'd0;
  endtask

  // Copy the source board into memory and paint the result area with a sentinel.
  task automatic commit();
    for (int i = 0; i < 64; i++) mem[SRC + i] = srcb[i];
    for (int i = 0; i < 28 * 64; i++) mem[DST + i] = 8'hAA;
  endtask

  task automatic run(input logic [7:0] id, output logic [31:0] status, output int writes);
    int w0;
    w0 = write_count;
    host_write(4'd1, SRC);
    host_write(4'd2, {{24{id[7]}}, id});
    host_write(4'd3, DST);
    host_write(4'd0, 32'd0);
    host_read(4'd0, status);
    writes = write_count - w0;
  endtask

  task automatic expect_board(input string tag, input int k, input int from, input int to,
                              input logic [7:0] id);
    logic [7:0] e;
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      e = (i == to) ? id : (i == from) ? 8'h00 : srcb[i];
      if (mem[DST + k * 64 + i] !== e) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic rook_board();
    clear_src();
    srcb[0] = 8'd9; srcb[8] = 8'd1; srcb[3] = 8'hFF;
    commit();
  endtask

  task automatic check_rook(input string tag, input logic [31:0] st, input int wr);
    check({tag, "_count"}, st[7:0], 32'd3);
    check({tag, "_ovf"}, 32'(st[31]), 32'd0);
    check({tag, "_writes"}, 32'(wr), 32'd192);
    expect_board({tag, "_b0"}, 0, 0, 1, 8'd9);
    expect_board({tag, "_b1"}, 1, 0, 2, 8'd9);
    expect_board({tag, "_b2"}, 2, 0, 3, 8'd9);
    check({tag, "_b3_untouched"}, 32'(mem[DST + 192]), 32'hAA);
  endtask

  initial begin
    logic [31:0] st;
    int wr, n, diff, wc;

    rst = 1'b1; sel = 1'b0;
    s_address = 4'd0; s_read = 1'b0; s_write = 1'b0; s_writedata = 32'd0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = 32'd0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Reset state.
    #1;
    check("rst_master_read", 32'(m_read), 32'd0);
    check("rst_master_write", 32'(m_write), 32'd0);
    check("rst_waitrequest", 32'(s_waitrequest), 32'd0);
    host_read(4'd0, st);
    check("rst_status", st, 32'd0);
    host_read(4'd1, st);
    check("rst_src_reg", st, 32'd0);

    // Rook with a blocking own pawn and a capturable black pawn.
    rook_board();
    run(8'd9, st, wr);
    check_rook("rook", st, wr);
    for (int i = 0; i < 192; i++) ref_img[i] = mem[DST + i];

    // Same board under random master stalls: identical image.
    commit();
    stall_en = 1'b1;
    run(8'd9, st, wr);
    stall_en = 1'b0;
    diff = 0;
    for (int i = 0; i < 192; i++) if (mem[DST + i] !== ref_img[i]) diff++;
    check("stall_count", st[7:0], 32'd3);
    check("stall_writes", 32'(wr), 32'd192);
    check("stall_image_diff", 32'(diff), 32'd0);

    // Lone queen in the centre: exactly 27 moves, no overflow.
    clear_src();
    srcb[27] = 8'd39;
    commit();
    run(8'd39, st, wr);
    check("q27_count", st[7:0], 32'd27);
    check("q27_ovf", 32'(st[31]), 32'd0);
    check("q27_writes", 32'(wr), 32'd1728);
    expect_board("q27_b0_n", 0, 27, 35, 8'd39);
    expect_board("q27_b26_sw", 26, 27, 0, 8'd39);

    // Same queen with an 8-move cap: overflow, no ninth board.
    sel = 1'b1;
    commit();
    run(8'd39, st, wr);
    check("q8_count", st[7:0], 32'd8);
    check("q8_ovf", 32'(st[31]), 32'd1);
    check("q8_writes", 32'(wr), 32'd512);
    expect_board("q8_b4_s", 4, 27, 19, 8'd39);
    expect_board("q8_b7_e", 7, 27, 28, 8'd39);
    check("q8_b8_untouched", 32'(mem[DST + 8 * 64]), 32'hAA);
    sel = 1'b0;

    // Bishop in the corner: NW diagonal only, no wrap onto sq16.
    clear_src();
    srcb[7] = 8'd29;
    commit();
    run(8'd29, st, wr);
    check("bishop_count", st[7:0], 32'd7);
    for (int k = 0; k < 7; k++) expect_board($sformatf("bishop_b%0d", k), k, 7, 14 + 7 * k, 8'd29);

    // Black rook (ID -9): S ray to the edge, W ray ending in a capture.
    clear_src();
    srcb[63] = 8'hF7; srcb[61] = 8'd1;
    commit();
    run(8'hF7, st, wr);
    check("brook_count", st[7:0], 32'd9);
    expect_board("brook_b0_s", 0, 63, 55, 8'hF7);
    expect_board("brook_b8_cap", 8, 63, 61, 8'hF7);

    // Non-slider and absent pieces produce nothing.
    clear_src();
    srcb[10] = 8'd3; srcb[0] = 8'd1;
    commit();
    run(8'd3, st, wr);
    check("pawn_status", st, 32'd0);
    check("pawn_writes", 32'(wr), 32'd0);
    run(8'd9, st, wr);
    check("absent_status", st, 32'd0);
    check("absent_writes", 32'(wr), 32'd0);

    // Reset in the middle of the second result board, then a clean rerun.
    rook_board();
    wc = write_count;
    host_write(4'd1, SRC);
    host_write(4'd2, 32'd9);
    host_write(4'd3, DST);
    host_write(4'd0, 32'd0);
    n = 0;
    while (write_count < wc + 74 && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout_fail("mid_run_wait");
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_master_write", 32'(m_write), 32'd0);
    check("rstmid_master_read", 32'(m_read), 32'd0);
    wc = write_count;
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_no_more_writes", 32'(write_count - wc), 32'd0);
    host_read(4'd0, st);
    check("rstmid_status", st, 32'd0);
    host_read(4'd3, st);
    check("rstmid_dst_reg", st, 32'd0);
    commit();
    run(8'd9, st, wr);
    check_rook("rerun", st, wr);

    check("never_read_and_write", 32'(both_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
